seg_scan_driver: RTL

Time-multiplexed 8-digit 7-segment scan driver. It sits directly downstream of the key-scan and decode logic.
- Upstream logic writes per-digit codes into an internal 8-entry digit buffer.
- The block rotates the digit select, with a blanking dead-time between digits to prevent ghosting.
- It drives the active-low digit-select and segment pins of the board display.

---
 rtl/seg_scan_driver_if.sv | 13 +
 rtl/seg_scan_driver.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Digit-buffer write bus for seg_scan_driver.
//   wr_en   : write strobe, one buffer entry per asserted cycle
//   wr_addr : digit index 0..7
//   wr_data : [5]=blank, [4]=dp on, [3:0]=hex value
// master drives the bus (upstream decode logic), slave receives it (scan driver).
interface seg_scan_driver_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [5:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scan driver.
// Each digit slot lasts DIV = F_CLK/F_SCAN cycles: BLANK_CYCLES dark cycles to
// suppress ghosting, then the slot's digit is driven for the rest of the slot.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr          : digit-buffer write bus (slave modport)
//   dig_en      : per-digit enable, sampled when a slot's digit is latched
//   cs          : digit select, active-low, one-hot-low while driving
//   o_seg       : segments {dp,g,f,e,d,c,b,a}, active-low
//   scan_pos    : index of the current slot
//   frame_done  : one-cycle pulse on the first cycle of slot 0 after a wrap
module seg_scan_driver #(
    parameter int unsigned F_CLK        = 50000000,
    parameter int unsigned F_SCAN       = 1000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_driver_if.slave    wr,
    input  logic [7:0]          dig_en,
    output logic [7:0]          cs,
    output logic [7:0]          o_seg,
    output logic [2:0]          scan_pos,
    output logic                frame_done
);

    localparam int unsigned DIV   = F_CLK / F_SCAN;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LATCH = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        StBlank,
        StDrive
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       scan_pos_q, scan_pos_d;
    logic [7:0]       cs_q, cs_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0][5:0]  buf_q, buf_d;

    // Active-low segment pattern; dp (bit 7) lit when code[4] is set.
    function automatic logic [7:0] decode(input logic [5:0] code);
        logic [6:0] s;
        case (code[3:0])
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return {~code[4], s};
    endfunction

    always_comb begin
        buf_d = buf_q;
        if (wr.wr_en) begin
            buf_d[wr.wr_addr] = wr.wr_data;
        end
    end

    always_comb begin
        cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        state_d      = state_q;
        scan_pos_d   = scan_pos_q;
        cs_d         = cs_q;
        seg_d        = seg_q;
        frame_done_d = 1'b0;

        case (state_q)
            StBlank: begin
                if (cnt_q == CNT_LATCH) begin
                    state_d = StDrive;
                    // buf_q is the pre-write value, so a same-cycle write to
                    // this address only shows on the next visit.
                    if (dig_en[scan_pos_q] && !buf_q[scan_pos_q][5]) begin
                        cs_d  = ~(8'd1 << scan_pos_q);
                        seg_d = decode(buf_q[scan_pos_q]);
                    end else begin
                        cs_d  = 8'hFF;
                        seg_d = 8'hFF;
                    end
                end
            end
            StDrive: begin
                if (cnt_q == CNT_LAST) begin
                    state_d      = StBlank;
                    scan_pos_d   = scan_pos_q + 3'd1;
                    cs_d         = 8'hFF;
                    seg_d        = 8'hFF;
                    frame_done_d = (scan_pos_q == 3'd7);
                end
            end
            default: begin
                state_d = StBlank;
                cs_d    = 8'hFF;
                seg_d   = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBlank;
            cnt_q        <= '0;
            scan_pos_q   <= 3'd0;
            cs_q         <= 8'hFF;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
            buf_q        <= {8{6'b100000}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            scan_pos_q   <= scan_pos_d;
            cs_q         <= cs_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            buf_q        <= buf_d;
        end
    end

    assign cs         = cs_q;
    assign o_seg      = seg_q;
    assign scan_pos   = scan_pos_q;
    assign frame_done = frame_done_q;

endmodule
